// File: rtl/apple_spawner_multi.sv
// Multi-apple spawner: keeps N_APPLES positions on the grid and respawns each eaten apple at a random
// free cell, rejecting off-grid, apple-occupied and body-occupied candidates (body scanned serially).
module apple_spawner_multi #(
  parameter  int COORD_W   = 4,
  parameter  int GRID_X    = 16,
  parameter  int GRID_Y    = 16,
  parameter  int MAX_LEN   = 50,
  parameter  int N_APPLES  = 2,
  parameter  int MAX_TRIES = 8,
  localparam int EW        = 2 * COORD_W,
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int SLOT_W    = (N_APPLES > 1) ? $clog2(N_APPLES) : 1,
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_reset,
  input  logic [COORD_W-1:0]       x,
  input  logic [COORD_W-1:0]       y,
  input  logic [COORD_W-1:0]       randX,
  input  logic [COORD_W-1:0]       randY,
  input  logic                     goodColl,
  input  logic [SLOT_W-1:0]        eat_idx,
  input  logic [MAX_LEN*EW-1:0]    body,
  input  logic [LEN_W-1:0]         body_len,
  output logic                     apple,
  output logic [N_APPLES-1:0]      apple_valid,
  output logic [N_APPLES*EW-1:0]   apple_pos,
  output logic                     busy,
  output logic                     stuck
);

  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, COMMIT} state_t;

  state_t              state;
  logic [N_APPLES-1:0] pending;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   next_slot;
  logic [EW-1:0]       cand;
  logic [EW-1:0]       cand_live;
  logic [EW-1:0]       body_entry;
  logic [LEN_W-1:0]    lc;
  logic [LEN_W-1:0]    idx;
  logic [TRY_W-1:0]    tries;
  logic                off_grid;
  logic                clash;
  logic                eat_ok;

  function automatic logic [TRY_W-1:0] tries_sat_inc(input logic [TRY_W-1:0] t);
    if (int'(t) >= MAX_TRIES) return t;
    return t + 1'b1;
  endfunction

  assign cand_live = {randX, randY};
  assign off_grid  = (int'(randX) >= GRID_X) || (int'(randY) >= GRID_Y);
  assign eat_ok    = goodColl && (int'(eat_idx) < N_APPLES) && apple_valid[eat_idx];
  assign busy      = (state != IDLE);
  assign stuck     = (int'(tries) >= MAX_TRIES);

  always_comb begin
    next_slot = '0;
    for (int i = N_APPLES - 1; i >= 0; i--)
      if (pending[i]) next_slot = SLOT_W'(i);
  end

  // The slot being spawned is excluded: its stale position must not block itself.
  always_comb begin
    clash = 1'b0;
    for (int j = 0; j < N_APPLES; j++)
      if (apple_valid[j] && (SLOT_W'(j) != slot) && (apple_pos[j*EW +: EW] == cand_live))
        clash = 1'b1;
  end

  always_comb begin
    body_entry = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx == LEN_W'(i)) body_entry = body[i*EW +: EW];
  end

  always_comb begin
    apple = 1'b0;
    for (int j = 0; j < N_APPLES; j++)
      if (apple_valid[j] && (apple_pos[j*EW +: EW] == {x, y})) apple = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '1;
      slot        <= '0;
      cand        <= '0;
      lc          <= '0;
      idx         <= '0;
      tries       <= '0;
      apple_valid <= '0;
      apple_pos   <= '0;
    end else if (s_reset) begin
      state       <= IDLE;
      pending     <= '1;
      slot        <= '0;
      cand        <= '0;
      lc          <= '0;
      idx         <= '0;
      tries       <= '0;
      apple_valid <= '0;
      apple_pos   <= '0;
    end else begin
      // An eaten apple is always a valid one, so it never aliases the slot being committed.
      if (eat_ok) begin
        apple_valid[eat_idx] <= 1'b0;
        pending[eat_idx]     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|pending) begin
            slot  <= next_slot;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          cand <= cand_live;
          lc   <= body_len;
          if (off_grid || clash) begin
            tries <= tries_sat_inc(tries);
          end else if (body_len == '0) begin
            state <= COMMIT;
          end else begin
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (body_entry == cand) begin
            tries <= tries_sat_inc(tries);
            state <= SAMPLE;
          end else if (idx == lc - 1'b1) begin
            state <= COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMMIT: begin
          apple_pos[slot*EW +: EW] <= cand;
          apple_valid[slot]        <= 1'b1;
          pending[slot]            <= 1'b0;
          tries                    <= '0;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_spawner_multi.sv
// Bench for apple_spawner_multi: scoreboard of expected commits plus a table of pixel-hit vectors
// and hand-written sequences for rejection, eating, stuck and game restart.
module tb_apple_spawner_multi;

  localparam int MAX_LEN = 50;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_reset;
  logic [3:0]           x, y, randX, randY;
  logic                 goodColl;
  logic [0:0]           eat_idx;
  logic [MAX_LEN*8-1:0] body;
  logic [5:0]           body_len;
  logic                 apple;
  logic [1:0]           apple_valid;
  logic [15:0]          apple_pos;
  logic                 busy;
  logic                 stuck;

  apple_spawner_multi #(.GRID_X(12)) dut (
    .clk(clk), .reset(reset), .s_reset(s_reset), .x(x), .y(y),
    .randX(randX), .randY(randY), .goodColl(goodColl), .eat_idx(eat_idx),
    .body(body), .body_len(body_len), .apple(apple), .apple_valid(apple_valid),
    .apple_pos(apple_pos), .busy(busy), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [7:0] pos;
  } sb_item_t;

  typedef struct {
    logic [3:0] vx;
    logic [3:0] vy;
    logic       exp;
  } vec_t;

  sb_item_t sb[$];
  vec_t     vecs[6];
  int       n_vec = 0;
  int       n_bad = 0;
  logic [1:0] prev_valid = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int j, input int bound, output int edges);
    edges = 0;
    while (!apple_valid[j] && edges < bound) begin
      step();
      edges++;
    end
    check($sformatf("wait_valid%0d", j), {31'b0, apple_valid[j]}, 1);
  endtask

  // Every rising apple_valid bit must match the oldest expected commit.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (apple_valid[j] && !prev_valid[j]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_commit%0d", j), {24'b0, apple_pos[j*8 +: 8]}, 32'hFFFF_FFFF);
        end else begin
          sb_item_t e;
          e = sb.pop_front();
          check("sb_slot", j, e.slot);
          check("sb_pos", {24'b0, apple_pos[j*8 +: 8]}, {24'b0, e.pos});
        end
      end
    end
    prev_valid = apple_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    vecs[0] = '{4'd5, 4'd8, 1'b1};
    vecs[1] = '{4'd2, 4'd3, 1'b1};
    vecs[2] = '{4'd1, 4'd1, 1'b0};
    vecs[3] = '{4'd3, 4'd2, 1'b0};
    vecs[4] = '{4'd8, 4'd5, 1'b0};
    vecs[5] = '{4'd5, 4'd3, 1'b0};

    reset = 1'b1; s_reset = 1'b0; goodColl = 1'b0; eat_idx = 1'b0;
    x = 4'd0; y = 4'd0; randX = 4'd5; randY = 8;
    body = '0; body_len = 6'd4;
    body[0 +: 8] = 8'h11; body[8 +: 8] = 8'h12; body[16 +: 8] = 8'h13; body[24 +: 8] = 8'h14;

    // T1: reset state, then first spawn with Lc=4 lands at edge 7
    step(); step();
    check("rst_valid", {30'b0, apple_valid}, 0);
    check("rst_apple", {31'b0, apple}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_stuck", {31'b0, stuck}, 0);
    check("rst_pos", {16'b0, apple_pos}, 0);
    sb.push_back('{0, 8'h58});
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) check("t1_busy", {31'b0, busy}, 1);
      if (e == 6) check("t1_not_yet", {30'b0, apple_valid}, 0);
      if (e == 7) begin
        check("t1_valid_e7", {30'b0, apple_valid}, 2'b01);
        check("t1_pos0", {24'b0, apple_pos[7:0]}, 8'h58);
      end
    end

    // T2: apple 1 blocked by apple 0 until the candidate changes
    repeat (20) step();
    check("t2_blocked", {31'b0, apple_valid[1]}, 0);
    check("t2_busy", {31'b0, busy}, 1);
    sb.push_back('{1, 8'h23});
    randX = 4'd2; randY = 4'd3;
    wait_valid(1, 20, edges);
    check("t2_pos1", {24'b0, apple_pos[15:8]}, 8'h23);

    for (int i = 0; i < 6; i++) begin
      x = vecs[i].vx; y = vecs[i].vy;
      #1;
      check($sformatf("vec%0d_apple", i), {31'b0, apple}, {31'b0, vecs[i].exp});
    end

    // T5 + T3: eat apple 1, respawn blocked by body[0]=0x48 until candidate moves
    body[0 +: 8] = 8'h48;
    randX = 4'd4; randY = 4'd8;
    goodColl = 1'b1; eat_idx = 1'b1;
    step();
    goodColl = 1'b0;
    check("t5_eaten", {30'b0, apple_valid}, 2'b01);
    x = 4'd2; y = 4'd3; #1;
    check("t5_old_pos", {31'b0, apple}, 0);
    repeat (20) step();
    check("t3_body_block", {31'b0, apple_valid[1]}, 0);
    sb.push_back('{1, 8'h92});
    randX = 4'd9; randY = 4'd2;
    wait_valid(1, 20, edges);
    check("t3_latency", {31'b0, (edges == 6 || edges == 7)}, 1);
    x = 4'd9; y = 4'd2; #1;
    check("t3_apple", {31'b0, apple}, 1);

    // T4: off-grid x rejected each SAMPLE cycle; stuck exactly after 8 tries
    randX = 4'd13; randY = 4'd0;
    goodColl = 1'b1; eat_idx = 1'b0;
    step();
    goodColl = 1'b0;
    check("t4_eaten", {30'b0, apple_valid}, 2'b10);
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 8) check("t4_stuck_e8", {31'b0, stuck}, 0);
      if (e == 9) check("t4_stuck_e9", {31'b0, stuck}, 1);
    end
    repeat (5) step();
    check("t4_no_commit", {31'b0, apple_valid[0]}, 0);
    check("t4_stuck_sat", {31'b0, stuck}, 1);
    sb.push_back('{0, 8'hB0});
    randX = 4'd11;
    wait_valid(0, 20, edges);
    check("t4_stuck_clr", {31'b0, stuck}, 0);
    x = 4'd11; y = 4'd0; #1;
    check("t4_apple", {31'b0, apple}, 1);

    // T6: body collision builds stuck, then s_reset during the spawn
    randX = 4'd4; randY = 4'd8;
    goodColl = 1'b1; eat_idx = 1'b1;
    step();
    goodColl = 1'b0;
    repeat (25) step();
    check("t6_stuck", {31'b0, stuck}, 1);
    check("t6_busy", {31'b0, busy}, 1);
    s_reset = 1'b1;
    step();
    check("t6_sr_valid", {30'b0, apple_valid}, 0);
    check("t6_sr_stuck", {31'b0, stuck}, 0);
    check("t6_sr_busy", {31'b0, busy}, 0);
    check("t6_sr_pos", {16'b0, apple_pos}, 0);
    #1;
    check("t6_sr_apple", {31'b0, apple}, 0);
    s_reset = 1'b0;
    sb.push_back('{0, 8'h77});
    randX = 4'd7; randY = 4'd7;
    wait_valid(0, 20, edges);
    sb.push_back('{1, 8'h6A});
    randX = 4'd6; randY = 4'd10;
    wait_valid(1, 20, edges);
    step();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
